// File: rtl/dmem_mmio_responder_pkg.sv
// Shared constants for the dmem responder: MMIO register offsets, DEAL field
// positions, card range, dealer LFSR taps and the dealer state type.
package dmem_map_pkg;

  localparam logic [2:0] OFS_BTN   = 3'd0;
  localparam logic [2:0] OFS_DEAL  = 3'd1;
  localparam logic [2:0] OFS_LED   = 3'd2;
  localparam logic [2:0] OFS_HEX   = 3'd3;
  localparam logic [2:0] OFS_TIMER = 3'd4;

  localparam logic [31:0] MMIO_SPAN = 32'd8;

  localparam int unsigned DEAL_BUSY_BIT  = 31;
  localparam int unsigned DEAL_VALID_BIT = 30;

  localparam logic [3:0] CARD_MIN = 4'd1;
  localparam logic [3:0] CARD_MAX = 4'd13;

  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    IDLE,
    DRAW
  } dealer_state_e;

  function automatic logic card_in_range(input logic [3:0] v);
    return (v >= CARD_MIN) && (v <= CARD_MAX);
  endfunction

endpackage

// File: rtl/dmem_mmio_responder_card_dealer.sv
// Card dealer: free-running 16-bit Fibonacci LFSR plus a draw FSM that keeps
// sampling the low nibble until it lands in the card range.
module card_dealer
  import dmem_map_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  output logic [3:0] card,
  output logic       valid,
  output logic       busy
);

  dealer_state_e state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [3:0]    card_q, card_d;
  logic          valid_q, valid_d;

  assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      card_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      card_q  <= card_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    card_d  = card_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRAW;
          valid_d = 1'b0;
        end
      end
      DRAW: begin
        if (card_in_range(lfsr_q[3:0])) begin
          card_d  = lfsr_q[3:0];
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign card  = card_q;
  assign valid = valid_q;
  assign busy  = (state_q == DRAW);

endmodule

// File: rtl/dmem_mmio_responder.sv
// Responder for the processor dmem port: word RAM plus blackjack board MMIO.
// Optional free-running timer at MMIO offset 4 when MMIO_TIMER_EN is defined.
module dmem_mmio_responder
  import dmem_map_pkg::*;
#(
  parameter int unsigned RAM_DEPTH = 4096,
  parameter logic [31:0] MMIO_BASE = 32'h0000_1000,
  parameter int unsigned NUM_BTN   = 4,
  parameter int unsigned LED_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [31:0]        address_dmem,
  input  logic [31:0]        data,
  input  logic               wren,
  output logic [31:0]        q_dmem,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [LED_W-1:0]   led_out,
  output logic [31:0]        hex_out
);

  localparam int unsigned AW = $clog2(RAM_DEPTH);

  logic        ram_hit;
  logic        mmio_hit;
  logic [31:0] mmio_ofs;
  logic [2:0]  reg_sel;
  logic        mmio_wr;

  assign ram_hit  = address_dmem < 32'(RAM_DEPTH);
  assign mmio_ofs = address_dmem - MMIO_BASE;
  assign mmio_hit = (address_dmem >= MMIO_BASE) && (mmio_ofs < MMIO_SPAN);
  assign reg_sel  = mmio_ofs[2:0];
  assign mmio_wr  = wren && mmio_hit;

  logic [31:0] ram [RAM_DEPTH];

  always_ff @(posedge clock) begin
    if (wren && ram_hit) begin
      ram[address_dmem[AW-1:0]] <= data;
    end
  end

  logic [NUM_BTN-1:0] btn_sync1, btn_sync2, btn_prev, btn_status;
  logic [NUM_BTN-1:0] btn_set, btn_clr;

  assign btn_set = btn_sync2 & ~btn_prev;
  assign btn_clr = (mmio_wr && (reg_sel == OFS_BTN)) ? data[NUM_BTN-1:0] : '0;

  // Set is OR-ed in after the clear so a coincident edge survives the W1C.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_sync1  <= '0;
      btn_sync2  <= '0;
      btn_prev   <= '0;
      btn_status <= '0;
    end else begin
      btn_sync1  <= btn_in;
      btn_sync2  <= btn_sync1;
      btn_prev   <= btn_sync2;
      btn_status <= (btn_status & ~btn_clr) | btn_set;
    end
  end

  logic [LED_W-1:0] led_q;
  logic [31:0]      hex_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      led_q <= '0;
      hex_q <= '0;
    end else begin
      if (mmio_wr && (reg_sel == OFS_LED)) led_q <= data[LED_W-1:0];
      if (mmio_wr && (reg_sel == OFS_HEX)) hex_q <= data;
    end
  end

  assign led_out = led_q;
  assign hex_out = hex_q;

  logic [31:0] timer_rd;

`ifdef MMIO_TIMER_EN
  logic [31:0] timer_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
    end else if (mmio_wr && (reg_sel == OFS_TIMER)) begin
      timer_q <= data;
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end

  assign timer_rd = timer_q;
`else
  assign timer_rd = '0;
`endif

  logic       deal_start;
  logic [3:0] deal_card;
  logic       deal_valid;
  logic       deal_busy;

  assign deal_start = mmio_wr && (reg_sel == OFS_DEAL);

  card_dealer #(
    .LFSR_SEED(LFSR_SEED)
  ) u_dealer (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (deal_start),
    .card   (deal_card),
    .valid  (deal_valid),
    .busy   (deal_busy)
  );

  always_comb begin
    q_dmem = '0;
    if (ram_hit) begin
      q_dmem = ram[address_dmem[AW-1:0]];
    end else if (mmio_hit) begin
      case (reg_sel)
        OFS_BTN:   q_dmem = 32'(btn_status);
        OFS_DEAL: begin
          q_dmem[DEAL_BUSY_BIT]  = deal_busy;
          q_dmem[DEAL_VALID_BIT] = deal_valid;
          q_dmem[3:0]            = deal_card;
        end
        OFS_LED:   q_dmem = 32'(led_q);
        OFS_HEX:   q_dmem = hex_q;
        OFS_TIMER: q_dmem = timer_rd;
        default:   q_dmem = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed self-checking bench for dmem_mmio_responder (RAM, buttons, dealer,
// registers, reset abort, optional timer).
module tb_dmem_mmio_responder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int unsigned DEPTH = 4096;

  logic        clock;
  logic        reset_n;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [3:0]  btn_in;
  logic [15:0] led_out;
  logic [31:0] hex_out;

  int unsigned total = 0;
  int unsigned bad   = 0;

  dmem_mmio_responder #(
    .RAM_DEPTH(DEPTH),
    .MMIO_BASE(BASE),
    .NUM_BTN  (4),
    .LED_W    (16),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .address_dmem(address_dmem),
    .data        (data),
    .wren        (wren),
    .q_dmem      (q_dmem),
    .btn_in      (btn_in),
    .led_out     (led_out),
    .hex_out     (hex_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference LFSR: taps 16,14,13,11, shift left, feedback into bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    address_dmem = a;
    data         = d;
    wren         = 1'b1;
    @(negedge clock);
    wren = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    address_dmem = a;
    #1;
    v = q_dmem;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset_n = 1'b0;
    wren = 1'b0; btn_in = '0; address_dmem = '0; data = '0;
    repeat (3) @(negedge clock);
    total++; if (led_out !== 16'h0) begin bad++; $display("FAIL reset_led got=%h exp=0", led_out); end
    total++; if (hex_out !== 32'h0) begin bad++; $display("FAIL reset_hex got=%h exp=0", hex_out); end
    rd(BASE, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_btn got=%h exp=0", v); end
    rd(BASE + 1, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_deal got=%h exp=0", v); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_ram;
    logic [31:0] v;
    wr(32'd5, 32'h1234_5678);
    rd(32'd5, v);
    total++; if (v !== 32'h1234_5678) begin bad++; $display("FAIL ram_rd5 got=%h exp=12345678", v); end
    wr(32'd4095, 32'hCAFE_0001);
    rd(32'd4095, v);
    total++; if (v !== 32'hCAFE_0001) begin bad++; $display("FAIL ram_top got=%h exp=cafe0001", v); end
    // DEPTH+3 is outside RAM; with the default map it aliases HEX, still 0 here.
    rd(DEPTH + 3, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL ram_oob_rd got=%h exp=0", v); end
    wr(32'd3, 32'hA5A5_A5A5);
    wr(DEPTH + 3, 32'h0000_5A5A);
    rd(32'd3, v);
    total++; if (v !== 32'hA5A5_A5A5) begin bad++; $display("FAIL ram_no_alias got=%h exp=a5a5a5a5", v); end
    total++; if (hex_out !== 32'h0000_5A5A) begin bad++; $display("FAIL oob_hex got=%h exp=00005a5a", hex_out); end
  endtask

  task automatic test_buttons;
    logic [31:0] v;
    @(negedge clock);
    btn_in = 4'b0100;
    address_dmem = BASE;
    repeat (2) @(posedge clock);
    #1;
    total++; if (q_dmem !== 32'h0) begin bad++; $display("FAIL btn_early got=%h exp=0", q_dmem); end
    @(posedge clock);
    #1;
    total++; if (q_dmem !== 32'h4) begin bad++; $display("FAIL btn_edge got=%h exp=4", q_dmem); end
    wr(BASE, 32'h4);
    rd(BASE, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL btn_w1c got=%h exp=0", v); end
    btn_in = 4'b0000;
    repeat (4) @(negedge clock);
    btn_in = 4'b0100;
    repeat (2) @(posedge clock);
    // Edge pulse is now high: clear lands on the same edge that sets the bit.
    @(negedge clock);
    address_dmem = BASE; data = 32'h4; wren = 1'b1;
    @(negedge clock);
    wren = 1'b0;
    rd(BASE, v);
    total++; if (v !== 32'h4) begin bad++; $display("FAIL btn_set_wins got=%h exp=4", v); end
    wr(BASE, 32'hF);
    rd(BASE, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL btn_clr_all got=%h exp=0", v); end
    btn_in = 4'b0000;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_dealer;
    logic [15:0] m;
    int unsigned n;
    logic [3:0]  prev_card;
    logic [31:0] exp;
    bit          seen[16];
    for (int k = 0; k < 16; k++) seen[k] = 1'b0;
    prev_card = 4'd0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      address_dmem = BASE + 1; data = 32'(i); wren = 1'b1;
      @(negedge clock);
      // The first draw keeps writing DEAL through DRAW; those writes must be ignored.
      wren = (i == 0);
      m = m_lfsr;
      n = 0;
      while (!((m[3:0] >= 4'd1) && (m[3:0] <= 4'd13))) begin
        m = lfsr_step(m);
        n++;
      end
      #1;
      if (i < 4) begin
        exp = {1'b1, 1'b0, 26'b0, prev_card};
        total++; if (q_dmem !== exp) begin bad++; $display("FAIL deal_busy i=%0d got=%h exp=%h", i, q_dmem, exp); end
      end
      repeat (n + 1) @(negedge clock);
      wren = 1'b0;
      #1;
      exp = {1'b0, 1'b1, 26'b0, m[3:0]};
      total++; if (q_dmem !== exp) begin bad++; $display("FAIL deal_done i=%0d got=%h exp=%h", i, q_dmem, exp); end
      seen[q_dmem[3:0]] = 1'b1;
      prev_card = m[3:0];
      if (i == 0) begin
        repeat (2) @(negedge clock);
        #1;
        total++; if (q_dmem !== exp) begin bad++; $display("FAIL deal_hold got=%h exp=%h", q_dmem, exp); end
      end
    end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (seen[k] !== ((k >= 1) && (k <= 13))) begin
        bad++; $display("FAIL deal_cover card=%0d seen=%0b exp=%0b", k, seen[k], ((k >= 1) && (k <= 13)));
      end
    end
  endtask

  task automatic test_registers;
    logic [31:0] v;
    wr(BASE + 2, 32'hFFFF_ABCD);
    total++; if (led_out !== 16'hABCD) begin bad++; $display("FAIL led_out got=%h exp=abcd", led_out); end
    rd(BASE + 2, v);
    total++; if (v !== 32'h0000_ABCD) begin bad++; $display("FAIL led_rd got=%h exp=0000abcd", v); end
    wr(BASE + 3, 32'hDEAD_BEEF);
    rd(BASE + 3, v);
    total++; if (v !== 32'hDEAD_BEEF) begin bad++; $display("FAIL hex_rd got=%h exp=deadbeef", v); end
    total++; if (hex_out !== 32'hDEAD_BEEF) begin bad++; $display("FAIL hex_out got=%h exp=deadbeef", hex_out); end
    for (int o = 5; o < 8; o++) begin
      wr(BASE + 32'(o), 32'hFFFF_FFFF);
      rd(BASE + 32'(o), v);
      total++; if (v !== 32'h0) begin bad++; $display("FAIL rsvd_%0d got=%h exp=0", o, v); end
    end
    wr(32'd8, 32'h0000_0088);
    wr(BASE + 8, 32'hFFFF_FFFF);
    rd(BASE + 8, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL unmapped_rd got=%h exp=0", v); end
    rd(32'd8, v);
    total++; if (v !== 32'h0000_0088) begin bad++; $display("FAIL unmapped_wr got=%h exp=88", v); end
    total++; if (led_out !== 16'hABCD) begin bad++; $display("FAIL led_kept got=%h exp=abcd", led_out); end
  endtask

  task automatic test_timer;
    logic [31:0] v;
`ifdef MMIO_TIMER_EN
    wr(BASE + 4, 32'd100);
    rd(BASE + 4, v);
    total++; if (v !== 32'd100) begin bad++; $display("FAIL timer_load got=%0d exp=100", v); end
    repeat (5) @(negedge clock);
    #1;
    total++; if (q_dmem !== 32'd105) begin bad++; $display("FAIL timer_count got=%0d exp=105", q_dmem); end
    wr(BASE + 4, 32'hFFFF_FFFF);
    rd(BASE + 4, v);
    total++; if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL timer_max got=%h exp=ffffffff", v); end
    @(negedge clock);
    #1;
    total++; if (q_dmem !== 32'h0) begin bad++; $display("FAIL timer_wrap got=%h exp=0", q_dmem); end
`else
    wr(BASE + 4, 32'd123);
    rd(BASE + 4, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL timer_absent got=%h exp=0", v); end
`endif
  endtask

  task automatic test_reset_mid_draw;
    logic [31:0] v;
    wr(BASE + 2, 32'h0000_0005);
    wr(BASE + 3, 32'h0000_0007);
    @(negedge clock);
    btn_in = 4'b0001;
    repeat (3) @(negedge clock);
    rd(BASE, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL pre_rst_btn got=%h exp=1", v); end
    wr(BASE + 1, 32'h0);
    rd(BASE + 1, v);
    total++; if (v[31] !== 1'b1) begin bad++; $display("FAIL pre_rst_busy got=%b exp=1", v[31]); end
    reset_n = 1'b0;
    #1;
    total++; if (q_dmem !== 32'h0) begin bad++; $display("FAIL rst_deal got=%h exp=0", q_dmem); end
    total++; if (led_out !== 16'h0) begin bad++; $display("FAIL rst_led got=%h exp=0", led_out); end
    total++; if (hex_out !== 32'h0) begin bad++; $display("FAIL rst_hex got=%h exp=0", hex_out); end
    rd(BASE, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_btn got=%h exp=0", v); end
    btn_in = 4'b0000;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    test_reset;
    test_ram;
    test_buttons;
    test_dealer;
    test_registers;
    test_timer;
    test_reset_mid_draw;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
